// File: rtl/keypad_event_fifo.sv
// keypad_event_fifo: debounces keypad column activity and queues one key code per press in a 4-entry show-ahead FIFO
module keypad_event_fifo #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] column,
  input  logic [3:0] key,
  input  logic       rd_en,
  output logic [3:0] rd_data,
  output logic       empty,
  output logic       full,
  output logic [2:0] count,
  output logic       pressed,
  output logic       overflow
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic {IDLE, DOWN} state_t;
  state_t state, state_n;
  logic s1, s2;
  logic [CW-1:0] cnt, cnt_n;
  logic diff, hit, push, pop, wr;
  logic [1:0] rd_ptr, wr_ptr;
  logic [3:0] mem [4];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      state <= IDLE;
      cnt <= '0;
    end else begin
      s1 <= ~&column;
      s2 <= s1;
      state <= state_n;
      cnt <= cnt_n;
    end
  always_comb begin
    diff = s2 != (state == DOWN);
    hit = diff && cnt == LAST;
    state_n = hit ? (state == IDLE ? DOWN : IDLE) : state;
    cnt_n = (diff && !hit) ? cnt + 1'b1 : '0;
  end
  assign pressed = state == DOWN;
  assign push = hit && state == IDLE;
  assign pop = rd_en && !empty;
  // a full FIFO still accepts a push when the head leaves on the same edge
  assign wr = push && (!full || pop);
  assign empty = count == 3'd0;
  assign full = count == 3'd4;
  assign rd_data = empty ? 4'h0 : mem[rd_ptr];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count <= 3'd0;
      overflow <= 1'b0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      if (wr) wr_ptr <= wr_ptr + 2'd1;
      count <= count + {2'b0, wr} - {2'b0, pop};
      if (push && !wr) overflow <= 1'b1;
    end
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= key;
endmodule

// File: tb/tb_keypad_event_fifo.sv
// tb_keypad_event_fifo: table-driven check of debounce timing, FIFO ordering, overflow and reset behaviour
module tb_keypad_event_fifo;
  logic clk = 1'b0, rst = 1'b1, rd_en = 1'b0;
  logic [3:0] column = 4'hF, key = 4'h0;
  logic [3:0] rd_data;
  logic empty, full, pressed, overflow;
  logic [2:0] count;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  keypad_event_fifo #(.DEBOUNCE_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .column(column), .key(key), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full), .count(count),
    .pressed(pressed), .overflow(overflow)
  );

  typedef struct {
    string      name;
    logic [3:0] column;
    logic [3:0] key;
    logic       rd_en;
    int         cycles;
    logic       pressed;
    int         count;
    logic [3:0] rd_data;
    logic       overflow;
  } step_t;
  step_t tbl[$];

  function automatic void add(string n, logic [3:0] c, logic [3:0] k, logic r, int cy,
                              logic p, int cnt, logic [3:0] rd, logic ov);
    step_t s;
    s.name = n; s.column = c; s.key = k; s.rd_en = r; s.cycles = cy;
    s.pressed = p; s.count = cnt; s.rd_data = rd; s.overflow = ov;
    tbl.push_back(s);
  endfunction

  // one clean press held until it registers, then a clean release
  function automatic void press(string n, logic [3:0] k, int cnt, logic [3:0] head, logic ov);
    add({n, "_press"}, 4'b1011, k, 1'b0, 18, 1'b1, cnt, head, ov);
    add({n, "_rel"}, 4'hF, k, 1'b0, 18, 1'b0, cnt, head, ov);
  endfunction

  task automatic chk(string n, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", n, act, exp);
    end
  endtask

  task automatic chk_all(string n, logic p, int cnt, logic [3:0] rd, logic ov);
    chk({n, ".pressed"}, int'(pressed), int'(p));
    chk({n, ".count"}, int'(count), cnt);
    chk({n, ".empty"}, int'(empty), int'(cnt == 0));
    chk({n, ".full"}, int'(full), int'(cnt == 4));
    chk({n, ".overflow"}, int'(overflow), int'(ov));
    chk({n, ".rd_data"}, int'(rd_data), int'(rd));
  endtask

  task automatic run(int lo, int hi);
    for (int i = lo; i < hi; i++) begin
      column = tbl[i].column;
      key = tbl[i].key;
      rd_en = tbl[i].rd_en;
      repeat (tbl[i].cycles) @(posedge clk);
      #1;
      chk_all(tbl[i].name, tbl[i].pressed, tbl[i].count, tbl[i].rd_data, tbl[i].overflow);
    end
    rd_en = 1'b0;
  endtask

  initial begin
    int m1, m2;
    add("single_pre", 4'b1101, 4'h5, 1'b0, 17, 1'b0, 0, 4'h0, 1'b0);
    add("single_edge18", 4'b1101, 4'h5, 1'b0, 1, 1'b1, 1, 4'h5, 1'b0);
    add("single_hold", 4'b1101, 4'h5, 1'b0, 22, 1'b1, 1, 4'h5, 1'b0);
    add("single_rel_pre", 4'hF, 4'h5, 1'b0, 17, 1'b1, 1, 4'h5, 1'b0);
    add("single_rel", 4'hF, 4'h5, 1'b0, 1, 1'b0, 1, 4'h5, 1'b0);
    add("single_no_repush", 4'hF, 4'h5, 1'b0, 5, 1'b0, 1, 4'h5, 1'b0);
    add("single_pop", 4'hF, 4'h5, 1'b1, 1, 1'b0, 0, 4'h0, 1'b0);
    add("pop_empty", 4'hF, 4'h5, 1'b1, 2, 1'b0, 0, 4'h0, 1'b0);
    for (int j = 0; j < 12; j++)
      add($sformatf("bounce%0d", j), (j % 2 == 0) ? 4'hE : 4'hF, 4'h9, 1'b0, 5, 1'b0, 0, 4'h0, 1'b0);
    press("fill1", 4'h1, 1, 4'h1, 1'b0);
    press("fill2", 4'h2, 2, 4'h1, 1'b0);
    press("fill3", 4'h3, 3, 4'h1, 1'b0);
    press("fill4", 4'hA, 4, 4'h1, 1'b0);
    press("fill5", 4'h4, 4, 4'h1, 1'b1);
    add("drain1", 4'hF, 4'h0, 1'b1, 1, 1'b0, 3, 4'h2, 1'b1);
    add("drain2", 4'hF, 4'h0, 1'b1, 1, 1'b0, 2, 4'h3, 1'b1);
    add("drain3", 4'hF, 4'h0, 1'b1, 1, 1'b0, 1, 4'hA, 1'b1);
    add("drain4", 4'hF, 4'h0, 1'b1, 1, 1'b0, 0, 4'h0, 1'b1);
    m1 = tbl.size();
    press("pf1", 4'h6, 1, 4'h6, 1'b0);
    press("pf2", 4'h7, 2, 4'h6, 1'b0);
    press("pf3", 4'h8, 3, 4'h6, 1'b0);
    press("pf4", 4'h9, 4, 4'h6, 1'b0);
    add("fullpp_pre", 4'b1011, 4'hC, 1'b0, 17, 1'b0, 4, 4'h6, 1'b0);
    add("fullpp_edge", 4'b1011, 4'hC, 1'b1, 1, 1'b1, 4, 4'h7, 1'b0);
    add("fullpp_rel", 4'hF, 4'hC, 1'b0, 18, 1'b0, 4, 4'h7, 1'b0);
    add("fullpp_pop1", 4'hF, 4'h0, 1'b1, 1, 1'b0, 3, 4'h8, 1'b0);
    add("fullpp_pop2", 4'hF, 4'h0, 1'b1, 1, 1'b0, 2, 4'h9, 1'b0);
    add("fullpp_tail", 4'hF, 4'h0, 1'b1, 1, 1'b0, 1, 4'hC, 1'b0);
    add("fullpp_pop4", 4'hF, 4'h0, 1'b1, 1, 1'b0, 0, 4'h0, 1'b0);
    add("emptypp_pre", 4'b1110, 4'h3, 1'b0, 17, 1'b0, 0, 4'h0, 1'b0);
    add("emptypp_edge", 4'b1110, 4'h3, 1'b1, 1, 1'b1, 1, 4'h3, 1'b0);
    add("emptypp_rel", 4'hF, 4'h3, 1'b0, 18, 1'b0, 1, 4'h3, 1'b0);
    m2 = tbl.size();

    #1;
    chk_all("reset_initial", 1'b0, 0, 4'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    run(0, m1);

    // asynchronous reset mid-cycle with overflow set
    #2 rst = 1'b1;
    #1 chk_all("reset_async", 1'b0, 0, 4'h0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    run(m1, m2);

    // reset in the middle of a held press restarts the whole latency
    column = 4'b0111;
    key = 4'hB;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk_all("midpress_rst", 1'b0, 0, 4'h0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (17) @(posedge clk);
    #1 chk_all("midpress_pre", 1'b0, 0, 4'h0, 1'b0);
    @(posedge clk);
    #1 chk_all("midpress_push", 1'b1, 1, 4'hB, 1'b0);
    repeat (12) @(posedge clk);
    #1 chk_all("midpress_hold", 1'b1, 1, 4'hB, 1'b0);
    column = 4'hF;
    repeat (20) @(posedge clk);
    #1 chk_all("midpress_rel", 1'b0, 1, 4'hB, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
